// File: rtl/esdi_pkg.sv
// Shared types and constants for the ESDI serial command/status engine.
package esdi_pkg;

    localparam int ESDI_WORD_BITS = 17;
    localparam int ESDI_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        TX_SETUP,
        TX_REQ,
        TX_REL,
        RX_REQ,
        RX_REL,
        FINISH
    } state_t;

    // Bit appended to a data word so the full word carries an odd count of ones.
    function automatic logic parity_bit(input logic [ESDI_DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/esdi_sync2.sv
// Two-flop synchronizer for one asynchronous drive line.
module esdi_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let both flops sample on the same edge,
    // giving two real register stages instead of one collapsed wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/esdi_serial_link.sv
// Bit-serial ESDI command transmitter and status/config word receiver.
// Line outputs are active-low; the top level inverts them onto the cable.
module esdi_serial_link
    import esdi_pkg::*;
#(
    parameter int SETUP_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ESDI_DATA_BITS-1:0] cmd_word,
    input  logic [1:0]                cmd_resp_words,
    output logic                      resp_valid,
    output logic [ESDI_DATA_BITS-1:0] resp_word,
    output logic                      resp_parity_err,
    output logic                      done,
    output logic                      timeout,
    output logic                      esdi_transfer_req,
    output logic                      esdi_command_data,
    input  logic                      esdi_transfer_ack,
    input  logic                      esdi_confstat_data
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       LAST_BIT     = 5'(ESDI_WORD_BITS - 1);

    state_t                    state;
    logic                      ack_s;
    logic                      dat_s;
    logic [CNT_W-1:0]          cnt;
    logic [ESDI_DATA_BITS-1:0] tx_shift;   // bits still queued behind the one on the line
    logic [ESDI_WORD_BITS-1:0] rx_shift;
    logic [4:0]                bit_cnt;
    logic [1:0]                words_left;
    logic                      in_wait;
    logic                      ack_event;
    logic                      expired;

    esdi_sync2 u_sync_ack (.clk(clk), .rst(rst), .d(esdi_transfer_ack),  .q(ack_s));
    esdi_sync2 u_sync_dat (.clk(clk), .rst(rst), .d(esdi_confstat_data), .q(dat_s));

    // Request states wait for ACK high, release states wait for ACK low.
    assign in_wait   = state inside {TX_REQ, TX_REL, RX_REQ, RX_REL};
    assign ack_event = (state == TX_REQ || state == RX_REQ) ? ack_s : ~ack_s;
    assign expired   = in_wait && !ack_event && (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            tx_shift          <= '0;
            rx_shift          <= '0;
            bit_cnt           <= '0;
            words_left        <= '0;
            cmd_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_word         <= '0;
            resp_parity_err   <= 1'b0;
            done              <= 1'b0;
            timeout           <= 1'b0;
            esdi_transfer_req <= 1'b1;
            esdi_command_data <= 1'b1;
        end else begin
            resp_valid      <= 1'b0;
            resp_parity_err <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            cnt             <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_valid && cmd_ready) begin
                        tx_shift          <= {cmd_word[ESDI_DATA_BITS-2:0], parity_bit(cmd_word)};
                        esdi_command_data <= ~cmd_word[ESDI_DATA_BITS-1];
                        words_left        <= cmd_resp_words;
                        bit_cnt           <= '0;
                        cmd_ready         <= 1'b0;
                        state             <= TX_SETUP;
                    end else begin
                        // Held low through the done cycle so ready rises one cycle later.
                        cmd_ready <= 1'b1;
                    end
                end

                TX_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt               <= '0;
                        esdi_transfer_req <= 1'b0;
                        state             <= TX_REQ;
                    end
                end

                TX_REQ: begin
                    if (ack_event) begin
                        cnt               <= '0;
                        esdi_transfer_req <= 1'b1;
                        state             <= TX_REL;
                    end
                end

                TX_REL: begin
                    if (ack_event) begin
                        cnt <= '0;
                        if (bit_cnt != LAST_BIT) begin
                            esdi_command_data <= ~tx_shift[ESDI_DATA_BITS-1];
                            tx_shift          <= {tx_shift[ESDI_DATA_BITS-2:0], 1'b0};
                            bit_cnt           <= bit_cnt + 5'd1;
                            state             <= TX_SETUP;
                        end else if (words_left == 2'd0) begin
                            state <= FINISH;
                        end else begin
                            bit_cnt           <= '0;
                            esdi_transfer_req <= 1'b0;
                            state             <= RX_REQ;
                        end
                    end
                end

                RX_REQ: begin
                    if (ack_event) begin
                        cnt               <= '0;
                        rx_shift          <= {rx_shift[ESDI_WORD_BITS-2:0], dat_s};
                        esdi_transfer_req <= 1'b1;
                        state             <= RX_REL;
                    end
                end

                RX_REL: begin
                    if (ack_event) begin
                        cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            resp_valid      <= 1'b1;
                            resp_word       <= rx_shift[ESDI_WORD_BITS-1:1];
                            resp_parity_err <= ~^rx_shift;
                            words_left      <= words_left - 2'd1;
                            bit_cnt         <= '0;
                            if (words_left == 2'd1) begin
                                state <= FINISH;
                            end else begin
                                esdi_transfer_req <= 1'b0;
                                state             <= RX_REQ;
                            end
                        end else begin
                            bit_cnt           <= bit_cnt + 5'd1;
                            esdi_transfer_req <= 1'b0;
                            state             <= RX_REQ;
                        end
                    end
                end

                FINISH: begin
                    cnt   <= '0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase

            // Abort overrides whatever the wait state scheduled above; a partial
            // word is simply abandoned in the shift register.
            if (expired) begin
                cnt               <= '0;
                esdi_transfer_req <= 1'b1;
                done              <= 1'b1;
                timeout           <= 1'b1;
                state             <= IDLE;
            end
        end
    end

endmodule

// File: doc/esdi_serial_link.md
# esdi_serial_link

Bit-serial command/status engine for the ESDI drive interface inside `soc_bd`. Takes a 16-bit command word from the processor side and shifts it out MSB-first with odd parity, one bit per TRANSFER REQ/ACK handshake on COMMAND DATA. It then collects 0–3 17-bit status/configuration words from CONFIG/STATUS DATA. Its line outputs are active-low; the top level inverts them onto the cable.

## Interface
Parameters:
- `SETUP_CYCLES`, 8: clocks COMMAND DATA is held stable before REQ is asserted.
- `TIMEOUT_CYCLES`, 1_000_000: clocks allowed for any single ACK edge before abort.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine idle, command accepted when `cmd_valid & cmd_ready`.
- `cmd_word`  in  16  command, sent bit 15 first.
- `cmd_resp_words`  in  2  number of 17-bit words to read back (0–3).
- `resp_valid`  out  1  one-cycle pulse per received word.
- `resp_word`  out  16  received data bits.
- `resp_parity_err`  out  1  qualifies `resp_valid`; received word failed odd parity.
- `done`  out  1  one-cycle pulse at end of transaction.
- `timeout`  out  1  qualifies `done`; transaction aborted.
- `esdi_transfer_req`  out  1  active-low TRANSFER REQ to top.
- `esdi_command_data`  out  1  active-low COMMAND DATA to top.
- `esdi_transfer_ack`  in  1  TRANSFER ACK from drive, asynchronous.
- `esdi_confstat_data`  in  1  CONFIG/STATUS DATA from drive, asynchronous.

## Operation
- `esdi_transfer_ack` and `esdi_confstat_data` each pass through a 2-flop synchronizer. All decisions use the synchronized values `ack_s` and `dat_s`.
- Parity: bit 17 = `~^data`, so the 17-bit word has an odd count of ones. This rule applies to both transmit and receive.
- States: IDLE, TX_SETUP, TX_REQ, TX_REL, RX_REQ, RX_REL, FINISH.
- IDLE: `cmd_ready`=1. On accept, latch `{cmd_word, ~^cmd_word}` into a 17-bit shift register, latch the response count, clear the bit counter, and go to TX_SETUP.
- TX_SETUP: drive the current bit onto `esdi_command_data` (line high = bit 1, i.e. port low). Count `SETUP_CYCLES`, then go to TX_REQ.
- TX_REQ: assert `esdi_transfer_req` (port low). Wait for `ack_s`=1, then deassert REQ and go to TX_REL.
- TX_REL: wait for `ack_s`=0. Then:
  - bits remaining → shift and go to TX_SETUP;
  - 17 bits sent and response count is 0 → FINISH;
  - otherwise → RX_REQ.
- RX_REQ: assert REQ. On `ack_s`=1, sample `dat_s` into the receive shift register MSB-first, deassert REQ, and go to RX_REL.
- RX_REL: wait for `ack_s`=0. After the 17th bit of a word, pulse `resp_valid` with `resp_word` and `resp_parity_err`, then decrement the word count. If words remain → RX_REQ; otherwise → FINISH.
- FINISH: pulse `done` with `timeout`=0, then return to IDLE.
- Timeout: a counter clears on every state entry and increments in TX_REQ, TX_REL, RX_REQ and RX_REL. When it reaches `TIMEOUT_CYCLES`:
  - deassert REQ;
  - pulse `done`=1 with `timeout`=1 in the same cycle;
  - go to IDLE directly and discard any partial word.
- The next command's TX_SETUP does not wait for ACK to drop. The drive is expected to recover during the setup period.
- `cmd_valid` outside IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - `esdi_transfer_req`=1 and `esdi_command_data`=1 (deasserted/line low);
  - `cmd_ready`=1;
  - `resp_valid`=`done`=`timeout`=`resp_parity_err`=0;
  - `resp_word`=0.
- Reset mid-transaction returns to IDLE on the next edge and drops REQ immediately. No `done` pulse is produced.
- Accept cycle N: `cmd_ready`=0 from N+1. COMMAND DATA is valid from N+1, and REQ asserts at N+1+`SETUP_CYCLES`.
- ACK reaction: REQ deasserts 3 clocks after an ACK line edge (2 synchronizer flops + 1 state register).
- All outputs are registered. `esdi_command_data` is held through TX_REQ and TX_REL and changes only in TX_SETUP.
- `resp_valid` fires the cycle after the 17th falling ACK is seen. `done` follows the last `resp_valid` by ≥1 cycle and never coincides with it.
- `cmd_ready` returns to 1 the cycle after `done`.

## Structure
- Package `esdi_pkg`: state enum, `ESDI_WORD_BITS`=17, `ESDI_DATA_BITS`=16.
- Sub-module `esdi_sync2`: 2-flop synchronizer, one instance per asynchronous input. Everything else is flat in `esdi_serial_link`.

## Test plan
- Command 0x1234 with 0 response words, drive model ACKing after 5 clocks → 17 REQ cycles. Line bits are 0001_0010_0011_0100 then parity 0 (five ones → bit 0). One `done` pulse, `timeout`=0.
- Command 0x0000 with 1 response word; drive returns 0xA5A5 with parity 1 → `resp_valid` once, `resp_word`=0xA5A5, `resp_parity_err`=0, then `done`.
- 3 response words where the second has wrong parity → three `resp_valid` pulses with `resp_parity_err` sequence 0,1,0.
- Drive never raises ACK; `TIMEOUT_CYCLES`=100 → REQ drops, `done`=`timeout`=1 about 100 clocks after REQ, and the next command is accepted.
- `rst` asserted mid-response at bit 9 → REQ high on the next edge, `cmd_ready`=1, no `resp_valid`/`done`. A fresh command then completes normally.
- `cmd_valid` held during a transaction → exactly one transaction per accept, and COMMAND DATA is stable whenever REQ is asserted.
